// File: rtl/if_id_fifo.sv
// IF/ID decoupling buffer: small circular FIFO carrying (pc, inst) pairs from
// fetch to decode with valid/ready handshakes, full back-pressure and flush.
module if_id_fifo #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push, pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and head presentation come purely from registered state;
  // an empty buffer presents pc 0 / inst 0 (NOP) to decode.
  always_comb begin
    if_ready  = (count_q != FULL_CNT);
    id_valid  = (count_q != '0);
    id_pc     = id_valid ? pc_mem_q[rd_ptr_q]   : '0;
    id_inst   = id_valid ? inst_mem_q[rd_ptr_q] : '0;
    occupancy = count_q;
    push      = if_valid && if_ready;
    pop       = id_valid && id_ready;
  end

  // Next-state for pointers and count; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care outside the valid window so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem_q[wr_ptr_q]   <= if_pc;
      inst_mem_q[wr_ptr_q] <= if_inst;
    end
  end

  // Occupancy bound and pointer/count consistency (ignored by synthesis).
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(count_q) <= DEPTH);
      if (int'(count_q) == DEPTH)
        assert (wr_ptr_q == rd_ptr_q);
      else
        assert (((int'(wr_ptr_q) - int'(rd_ptr_q) + DEPTH) % DEPTH) == int'(count_q));
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: DEPTH=2 and DEPTH=3 instances against a queue model.
module tb_if_id_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH = 2 instance
  logic        rst2, v2, r2, fl2;
  logic [31:0] pc2, in2;
  logic        ifr2, idv2;
  logic [31:0] idpc2, idin2;
  logic [3:0]  occ2;

  // DEPTH = 3 instance
  logic        rst3, v3, r3, fl3;
  logic [31:0] pc3, in3;
  logic        ifr3, idv3;
  logic [31:0] idpc3, idin3;
  logic [3:0]  occ3;

  if_id_fifo #(.ADDR_W(32), .INST_W(32), .DEPTH(2), .CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst2), .if_valid(v2), .if_pc(pc2), .if_inst(in2),
    .if_ready(ifr2), .id_valid(idv2), .id_pc(idpc2), .id_inst(idin2),
    .id_ready(r2), .flush(fl2), .occupancy(occ2));

  if_id_fifo #(.ADDR_W(32), .INST_W(32), .DEPTH(3), .CNT_W(4)) u_d3 (
    .clk(clk), .rst(rst3), .if_valid(v3), .if_pc(pc3), .if_inst(in3),
    .if_ready(ifr3), .id_valid(idv3), .id_pc(idpc3), .id_inst(idin3),
    .id_ready(r3), .flush(fl3), .occupancy(occ3));

  int checks = 0;
  int errors = 0;

  logic [31:0] m2_pc[$], m2_in[$], m3_pc[$], m3_in[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare both instances with the model, apply this cycle's inputs to the
  // model, then advance one clock and settle past the edge.
  task automatic step();
    bit pu, po;
    chk("d2_id_valid", 32'(idv2), 32'(m2_pc.size() != 0));
    chk("d2_id_pc",    idpc2, (m2_pc.size() != 0) ? m2_pc[0] : 32'h0);
    chk("d2_id_inst",  idin2, (m2_in.size() != 0) ? m2_in[0] : 32'h0);
    chk("d2_occupancy", 32'(occ2), 32'(m2_pc.size()));
    chk("d2_if_ready", 32'(ifr2), 32'(m2_pc.size() != 2));
    chk("d3_id_valid", 32'(idv3), 32'(m3_pc.size() != 0));
    chk("d3_id_pc",    idpc3, (m3_pc.size() != 0) ? m3_pc[0] : 32'h0);
    chk("d3_id_inst",  idin3, (m3_in.size() != 0) ? m3_in[0] : 32'h0);
    chk("d3_occupancy", 32'(occ3), 32'(m3_pc.size()));
    chk("d3_if_ready", 32'(ifr3), 32'(m3_pc.size() != 3));

    pu = v2 && (m2_pc.size() != 2);
    po = r2 && (m2_pc.size() != 0);
    if (rst2 || fl2) begin
      m2_pc.delete(); m2_in.delete();
    end else begin
      if (po) begin void'(m2_pc.pop_front()); void'(m2_in.pop_front()); end
      if (pu) begin m2_pc.push_back(pc2); m2_in.push_back(in2); end
    end

    pu = v3 && (m3_pc.size() != 3);
    po = r3 && (m3_pc.size() != 0);
    if (rst3 || fl3) begin
      m3_pc.delete(); m3_in.delete();
    end else begin
      if (po) begin void'(m3_pc.pop_front()); void'(m3_in.pop_front()); end
      if (pu) begin m3_pc.push_back(pc3); m3_in.push_back(in3); end
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst2 = 1'b1; v2 = 1'b0; r2 = 1'b0; fl2 = 1'b0; pc2 = '0; in2 = '0;
    rst3 = 1'b1; v3 = 1'b0; r3 = 1'b0; fl3 = 1'b0; pc3 = '0; in3 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 1'b0; rst3 = 1'b0;

    // reset values
    chk("rst_occupancy", 32'(occ2), 32'h0);
    chk("rst_if_ready",  32'(ifr2), 32'h1);
    step();

    // streaming with decode always ready
    r2 = 1'b1; v2 = 1'b1;
    pc2 = 32'h00; in2 = 32'h2401_0000; step();
    chk("stream_pc0", idpc2, 32'h00);
    pc2 = 32'h04; in2 = 32'h2401_0004; step();
    chk("stream_pc4", idpc2, 32'h04);
    pc2 = 32'h08; in2 = 32'h2401_0008; step();
    chk("stream_pc8", idpc2, 32'h08);
    chk("stream_occ", 32'(occ2), 32'h1);
    v2 = 1'b0; step();
    step();

    // decode stall fills the buffer, then drains in order
    r2 = 1'b0; v2 = 1'b1;
    pc2 = 32'h00; in2 = 32'h1111_0000; step();
    pc2 = 32'h04; in2 = 32'h1111_0004; step();
    chk("stall_full_ready", 32'(ifr2), 32'h0);
    pc2 = 32'h08; in2 = 32'h1111_0008; step();
    chk("stall_refused_occ", 32'(occ2), 32'h2);
    r2 = 1'b1;
    step();
    chk("full_pop_push_occ", 32'(occ2), 32'h1);
    chk("full_pop_head", idpc2, 32'h04);
    step();
    v2 = 1'b0;
    chk("drain_head8", idpc2, 32'h08);
    step();
    step();

    // flush with concurrent push
    r2 = 1'b0; v2 = 1'b1;
    pc2 = 32'h30; in2 = 32'h3333_0030; step();
    pc2 = 32'h34; in2 = 32'h3333_0034; step();
    fl2 = 1'b1; pc2 = 32'h10; in2 = 32'h3333_0010; step();
    fl2 = 1'b0; v2 = 1'b0;
    chk("flush_valid", 32'(idv2), 32'h0);
    chk("flush_inst",  idin2, 32'h0);
    step();
    v2 = 1'b1; pc2 = 32'h20; in2 = 32'h3333_0020; step();
    v2 = 1'b0;
    chk("after_flush_pc", idpc2, 32'h20);
    r2 = 1'b1; step();
    step();

    // reset mid-operation with active push
    r2 = 1'b0; v2 = 1'b1;
    pc2 = 32'h50; in2 = 32'h5555_0050; step();
    pc2 = 32'h54; in2 = 32'h5555_0054; step();
    rst2 = 1'b1; pc2 = 32'h40; in2 = 32'h5555_0040; step();
    rst2 = 1'b0; v2 = 1'b0; r2 = 1'b1;
    chk("midrst_pc", idpc2, 32'h0);
    chk("midrst_ready", 32'(ifr2), 32'h1);
    step();
    step();

    // randomized traffic on both instances
    for (int i = 0; i < 300; i++) begin
      v2 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 2) != 0);
      fl2 = ($urandom_range(0, 19) == 0);
      pc2 = $urandom & 32'hFFFF_FFFC; in2 = $urandom;
      v3 = ($urandom_range(0, 3) != 0);
      r3 = ($urandom_range(0, 2) != 0);
      fl3 = ($urandom_range(0, 19) == 0);
      pc3 = $urandom & 32'hFFFF_FFFC; in3 = $urandom;
      step();
    end
    v2 = 1'b0; v3 = 1'b0; fl2 = 1'b0; fl3 = 1'b0; r2 = 1'b1; r3 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("final_d3_empty", 32'(occ3), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
